// File: rtl/if_pkg.sv
// if_pkg: types and constants shared by the instruction-fetch stage.
// The S_FAULT state only exists when IF_FETCH_FAULT_EN is defined.
package if_pkg;

  // Widest PC / instruction the queue entry can carry.
  localparam int IF_MAX_ADDR_W = 64;
  localparam int IF_MAX_INST_W = 32;

  // Byte distance between consecutive instruction words.
  localparam logic [IF_MAX_ADDR_W-1:0] PC_STEP = 64'd4;

`ifdef IF_FETCH_FAULT_EN
  typedef enum logic [1:0] {
    S_BOOT  = 2'd0,
    S_FETCH = 2'd1,
    S_FAULT = 2'd2
  } if_state_e;
`else
  typedef enum logic [1:0] {
    S_BOOT  = 2'd0,
    S_FETCH = 2'd1
  } if_state_e;
`endif

  // One fetch-queue entry: instruction word tagged with its PC and fault flag.
  typedef struct packed {
    logic [IF_MAX_ADDR_W-1:0] pc;
    logic [IF_MAX_INST_W-1:0] inst;
    logic                     fault;
  } if_entry_t;

endpackage

// File: rtl/if_fetch_fifo.sv
// if_fetch_fifo: small synchronous FIFO of fetch entries with flush.
// Flush wins over push/pop in the same cycle; the head entry is read
// combinationally so decode sees a pushed entry on the cycle after the push.
module if_fetch_fifo
  import if_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     flush,
  input  logic                     push,
  input  logic                     pop,
  input  if_entry_t                wdata,
  output if_entry_t                rdata,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     empty
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  if_entry_t         mem_q [DEPTH];
  if_entry_t         mem_d [DEPTH];
  logic [PW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]     count_q, count_d;

  // Next-state for storage, pointers and occupancy; pointers wrap naturally
  // because DEPTH is a power of two.
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) begin
        mem_d[wr_ptr_q] = wdata;
        wr_ptr_d        = wr_ptr_q + PW'(1);
      end
      if (pop) begin
        rd_ptr_d = rd_ptr_q + PW'(1);
      end
      count_d = count_q + CW'(push) - CW'(pop);
    end
  end

  // Storage is cleared on reset so the head reads as all-zero until filled.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  assign rdata = mem_q[rd_ptr_q];
  assign count = count_q;
  assign empty = (count_q == '0);

endmodule

// File: rtl/stage_if_fetch.sv
// stage_if_fetch: instruction-fetch stage feeding the IF/ID register.
// Owns the PC, issues sequential word fetches over a valid/ready channel,
// queues in-order responses and drains them into decode. A redirect flushes
// the queue and discards responses still in flight.
// Optional feature macro: IF_FETCH_FAULT_EN (fault tagging + issue stop).
module stage_if_fetch
  import if_pkg::*;
#(
  parameter int                    ADDR_WIDTH = 64,
  parameter int                    INST_WIDTH = 32,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC   = '0,
  parameter int                    FIFO_DEPTH = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  stall,
  input  logic                  redirect_valid,
  input  logic [ADDR_WIDTH-1:0] redirect_pc,
  output logic                  imem_req_valid,
  input  logic                  imem_req_ready,
  output logic [ADDR_WIDTH-1:0] imem_req_addr,
  input  logic                  imem_rsp_valid,
  input  logic [INST_WIDTH-1:0] imem_rsp_data,
  input  logic                  imem_rsp_err,
  output logic                  inst_valid,
  output logic [INST_WIDTH-1:0] inst,
  output logic [ADDR_WIDTH-1:0] pc,
  output logic                  inst_fault
);

  localparam int                    CW      = $clog2(FIFO_DEPTH) + 1;
  localparam logic [ADDR_WIDTH-1:0] STEP    = ADDR_WIDTH'(PC_STEP);
  localparam logic [CW:0]           DEPTH_W = (CW + 1)'(FIFO_DEPTH);

  if_state_e             state_q, state_d;
  logic [ADDR_WIDTH-1:0] fetch_pc_q, fetch_pc_d;
  logic [ADDR_WIDTH-1:0] rsp_pc_q, rsp_pc_d;
  logic [CW-1:0]         inflight_q, inflight_d;
  logic [CW-1:0]         drop_cnt_q, drop_cnt_d;

  logic [CW-1:0]         fifo_count;
  logic                  fifo_empty;
  if_entry_t             head;
  if_entry_t             push_entry;
  logic [CW:0]           occupancy;
  logic                  req_fire;
  logic                  rsp_drop;
  logic                  fifo_push;
  logic                  fifo_pop;

  // Queue entries plus in-flight requests never exceed the queue size, so a
  // kept response always has a free slot and the memory needs no backpressure.
  assign occupancy      = {1'b0, fifo_count} + {1'b0, inflight_q};
  assign imem_req_valid = (state_q == S_FETCH) && (occupancy < DEPTH_W) && !redirect_valid;
  assign imem_req_addr  = fetch_pc_q;
  assign req_fire       = imem_req_valid && imem_req_ready;

  // Stale beats (from before a redirect) are consumed without being queued.
  assign rsp_drop  = imem_rsp_valid && (drop_cnt_q != '0);
  assign fifo_push = imem_rsp_valid && !rsp_drop && !redirect_valid;

  assign inst_valid = !fifo_empty && !redirect_valid;
  assign fifo_pop   = inst_valid && !stall;

  // Build the entry for an accepted response, tagging it with its PC.
  always_comb begin
    push_entry      = '0;
    push_entry.pc   = IF_MAX_ADDR_W'(rsp_pc_q);
    push_entry.inst = IF_MAX_INST_W'(imem_rsp_data);
`ifdef IF_FETCH_FAULT_EN
    push_entry.fault = imem_rsp_err;
`endif
  end

  // Next-state for PCs, counters and the FSM; a redirect overrides all else.
  always_comb begin
    state_d    = state_q;
    fetch_pc_d = fetch_pc_q;
    rsp_pc_d   = rsp_pc_q;
    inflight_d = inflight_q;
    drop_cnt_d = drop_cnt_q;
    if (redirect_valid) begin
      fetch_pc_d = redirect_pc;
      rsp_pc_d   = redirect_pc;
      inflight_d = inflight_q - CW'(imem_rsp_valid);
      drop_cnt_d = inflight_q - CW'(imem_rsp_valid);
      state_d    = S_FETCH;
    end else begin
      if (req_fire) begin
        fetch_pc_d = fetch_pc_q + STEP;
      end
      inflight_d = inflight_q + CW'(req_fire) - CW'(imem_rsp_valid);
      if (rsp_drop) begin
        drop_cnt_d = drop_cnt_q - CW'(1);
      end
      if (fifo_push) begin
        rsp_pc_d = rsp_pc_q + STEP;
      end
      case (state_q)
        S_BOOT:  state_d = S_FETCH;
`ifdef IF_FETCH_FAULT_EN
        S_FETCH: if (fifo_push && imem_rsp_err) state_d = S_FAULT;
`endif
        default: state_d = state_q;
      endcase
    end
  end

  // All stage state is held here and cleared immediately by reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= S_BOOT;
      fetch_pc_q <= RESET_PC;
      rsp_pc_q   <= RESET_PC;
      inflight_q <= '0;
      drop_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      rsp_pc_q   <= rsp_pc_d;
      inflight_q <= inflight_d;
      drop_cnt_q <= drop_cnt_d;
    end
  end

  if_fetch_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .flush (redirect_valid),
    .push  (fifo_push),
    .pop   (fifo_pop),
    .wdata (push_entry),
    .rdata (head),
    .count (fifo_count),
    .empty (fifo_empty)
  );

  assign inst = head.inst[INST_WIDTH-1:0];
  assign pc   = head.pc[ADDR_WIDTH-1:0];

`ifdef IF_FETCH_FAULT_EN
  assign inst_fault = head.fault;
`else
  // Without fault support the error input and stored fault bit are ignored.
  logic unused_rsp_err;
  logic unused_head_fault;
  assign unused_rsp_err    = imem_rsp_err;
  assign unused_head_fault = head.fault;
  assign inst_fault        = 1'b0;
`endif

endmodule

// File: tb/tb_stage_if_fetch.sv
// tb_stage_if_fetch: directed bench for stage_if_fetch with a behavioural
// in-order instruction memory of programmable latency. A second instance
// starting near the top of the address space exercises PC wrap-around.
// Fault scenarios depend on IF_FETCH_FAULT_EN.
module tb_stage_if_fetch;

  localparam int AW = 64;
  localparam int IW = 32;
  localparam logic [AW-1:0] WRAP_PC = 64'hFFFF_FFFF_FFFF_FFF8;

  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic          stall = 1'b0;
  logic          redirect_valid = 1'b0;
  logic [AW-1:0] redirect_pc = '0;
  logic          imem_req_valid;
  logic          imem_req_ready = 1'b1;
  logic [AW-1:0] imem_req_addr;
  logic          imem_rsp_valid = 1'b0;
  logic [IW-1:0] imem_rsp_data = '0;
  logic          imem_rsp_err = 1'b0;
  logic          inst_valid;
  logic [IW-1:0] inst;
  logic [AW-1:0] pc;
  logic          inst_fault;

  logic          w_req_valid;
  logic [AW-1:0] w_req_addr;
  logic          w_rsp_valid = 1'b0;
  logic [IW-1:0] w_rsp_data = '0;
  logic          w_inst_valid;
  logic [IW-1:0] w_inst;
  logic [AW-1:0] w_pc;
  logic          w_inst_fault;
  logic          w_fire;
  logic [AW-1:0] w_fire_addr;

  int checks = 0;
  int failures = 0;

  int            mem_lat = 1;
  logic          err_armed = 1'b0;
  logic [AW-1:0] err_addr = '0;
  logic [AW-1:0] pend_addr [$];
  int            pend_due [$];
  int            cyc = 0;
  int            n_fire = 0;

  always #5 clk = ~clk;

  // Memory content: each word is derived from its own address.
  function automatic logic [IW-1:0] mem_word(input logic [AW-1:0] a);
    return a[31:0] ^ 32'hDEAD_0000;
  endfunction

  stage_if_fetch #(
    .ADDR_WIDTH (AW),
    .INST_WIDTH (IW),
    .RESET_PC   ('0),
    .FIFO_DEPTH (4)
  ) dut (
    .clk            (clk),
    .reset          (rst_n),
    .stall          (stall),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .imem_req_valid (imem_req_valid),
    .imem_req_ready (imem_req_ready),
    .imem_req_addr  (imem_req_addr),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rsp_data  (imem_rsp_data),
    .imem_rsp_err   (imem_rsp_err),
    .inst_valid     (inst_valid),
    .inst           (inst),
    .pc             (pc),
    .inst_fault     (inst_fault)
  );

  stage_if_fetch #(
    .ADDR_WIDTH (AW),
    .INST_WIDTH (IW),
    .RESET_PC   (WRAP_PC),
    .FIFO_DEPTH (4)
  ) dut_wrap (
    .clk            (clk),
    .reset          (rst_n),
    .stall          (1'b0),
    .redirect_valid (1'b0),
    .redirect_pc    ('0),
    .imem_req_valid (w_req_valid),
    .imem_req_ready (1'b1),
    .imem_req_addr  (w_req_addr),
    .imem_rsp_valid (w_rsp_valid),
    .imem_rsp_data  (w_rsp_data),
    .imem_rsp_err   (1'b0),
    .inst_valid     (w_inst_valid),
    .inst           (w_inst),
    .pc             (w_pc),
    .inst_fault     (w_inst_fault)
  );

  // In-order memory: a request accepted at edge N is presented
  // mem_lat-1 cycles after that edge and consumed at the next edge.
  always @(posedge clk) begin
    logic [AW-1:0] junk_addr;
    int            junk_due;
    cyc++;
    if (!rst_n) begin
      pend_addr.delete();
      pend_due.delete();
      n_fire = 0;
    end else begin
      if (imem_rsp_valid && pend_addr.size() > 0) begin
        junk_addr = pend_addr.pop_front();
        junk_due  = pend_due.pop_front();
      end
      if (imem_req_valid && imem_req_ready) begin
        pend_addr.push_back(imem_req_addr);
        pend_due.push_back(cyc + mem_lat - 1);
        n_fire++;
      end
    end
    #1;
    if (rst_n && pend_addr.size() > 0 && pend_due[0] <= cyc) begin
      imem_rsp_valid = 1'b1;
      imem_rsp_data  = mem_word(pend_addr[0]);
      imem_rsp_err   = err_armed && (pend_addr[0] == err_addr);
    end else begin
      imem_rsp_valid = 1'b0;
      imem_rsp_data  = '0;
      imem_rsp_err   = 1'b0;
    end
  end

  // Single-cycle memory for the wrap-around instance.
  always @(posedge clk) begin
    w_fire      = rst_n && w_req_valid;
    w_fire_addr = w_req_addr;
    #1;
    w_rsp_valid = w_fire;
    w_rsp_data  = w_fire ? mem_word(w_fire_addr) : '0;
  end

  // Assert reset for three cycles and release it on a falling edge.
  task automatic apply_reset();
    @(negedge clk);
    rst_n          = 1'b0;
    stall          = 1'b0;
    redirect_valid = 1'b0;
    err_armed      = 1'b0;
    mem_lat        = 1;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if (imem_req_valid !== 1'b0 || inst_valid !== 1'b0 || inst_fault !== 1'b0) begin
      failures++;
      $display("[TB] FAIL reset_valids: req_valid=%b inst_valid=%b fault=%b required 0/0/0",
               imem_req_valid, inst_valid, inst_fault);
    end
    checks++;
    if (inst !== '0 || pc !== '0 || imem_req_addr !== '0) begin
      failures++;
      $display("[TB] FAIL reset_values: inst=%h pc=%h req_addr=%h required 0/0/0",
               inst, pc, imem_req_addr);
    end
    rst_n = 1'b1;
    #1;
    checks++;
    if (imem_req_valid !== 1'b0) begin
      failures++;
      $display("[TB] FAIL boot_no_req: req_valid=%b required 0", imem_req_valid);
    end
    @(negedge clk);
    checks++;
    if (imem_req_valid !== 1'b1 || imem_req_addr !== '0) begin
      failures++;
      $display("[TB] FAIL first_req: req_valid=%b addr=%h required 1 addr=0",
               imem_req_valid, imem_req_addr);
    end
  endtask

  // Continues directly after test_reset: first request fires at this edge.
  task automatic test_run();
    logic [AW-1:0] exp_pc;
    @(negedge clk);
    checks++;
    if (inst_valid !== 1'b0) begin
      failures++;
      $display("[TB] FAIL run_latency: inst_valid=%b required 0", inst_valid);
    end
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      exp_pc = AW'(i * 4);
      checks++;
      if (inst_valid !== 1'b1 || pc !== exp_pc || inst !== mem_word(exp_pc)) begin
        failures++;
        $display("[TB] FAIL run_seq[%0d]: valid=%b pc=%h inst=%h required 1 pc=%h inst=%h",
                 i, inst_valid, pc, inst, exp_pc, mem_word(exp_pc));
      end
    end
  endtask

  task automatic test_backpressure();
    logic [AW-1:0] exp_pc;
    apply_reset();
    stall = 1'b1;
    repeat (3) @(negedge clk);
    for (int i = 0; i < 7; i++) begin
      @(negedge clk);
      checks++;
      if (inst_valid !== 1'b1 || pc !== '0) begin
        failures++;
        $display("[TB] FAIL stall_head[%0d]: valid=%b pc=%h required 1 pc=0", i, inst_valid, pc);
      end
    end
    checks++;
    if (imem_req_valid !== 1'b0 || n_fire !== 4 || pend_addr.size() !== 0) begin
      failures++;
      $display("[TB] FAIL stall_full: req_valid=%b fired=%0d pending=%0d required 0/4/0",
               imem_req_valid, n_fire, pend_addr.size());
    end
    stall = 1'b0;
    for (int i = 0; i < 8; i++) begin
      exp_pc = AW'(i * 4);
      checks++;
      if (inst_valid !== 1'b1 || pc !== exp_pc) begin
        failures++;
        $display("[TB] FAIL release_seq[%0d]: valid=%b pc=%h required 1 pc=%h",
                 i, inst_valid, pc, exp_pc);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_async_reset();
    int waited;
    stall = 1'b1;
    repeat (4) @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (inst_valid !== 1'b0 || imem_req_valid !== 1'b0 || pc !== '0 || imem_req_addr !== '0) begin
      failures++;
      $display("[TB] FAIL async_reset: valid=%b req=%b pc=%h addr=%h required 0/0/0/0",
               inst_valid, imem_req_valid, pc, imem_req_addr);
    end
    stall = 1'b0;
    repeat (3) @(negedge clk);
    rst_n  = 1'b1;
    waited = 0;
    while (inst_valid !== 1'b1 && waited < 20) begin
      @(negedge clk);
      waited++;
    end
    checks++;
    if (inst_valid !== 1'b1 || pc !== '0 || inst !== mem_word('0)) begin
      failures++;
      $display("[TB] FAIL post_reset_head: valid=%b pc=%h inst=%h required 1 pc=0 inst=%h",
               inst_valid, pc, inst, mem_word('0));
    end
  endtask

  task automatic test_redirect_inflight();
    int            waited;
    int            k;
    logic [AW-1:0] exp_pc;
    apply_reset();
    mem_lat = 4;
    waited  = 0;
    while (!(pend_addr.size() == 3 && !imem_rsp_valid && !inst_valid) && waited < 20) begin
      @(negedge clk);
      waited++;
    end
    checks++;
    if (pend_addr.size() != 3) begin
      failures++;
      $display("[TB] FAIL redir_setup: inflight=%0d required 3", pend_addr.size());
    end
    redirect_valid = 1'b1;
    redirect_pc    = 64'h100;
    #1;
    checks++;
    if (imem_req_valid !== 1'b0 || inst_valid !== 1'b0) begin
      failures++;
      $display("[TB] FAIL redir_mask: req_valid=%b inst_valid=%b required 0/0",
               imem_req_valid, inst_valid);
    end
    @(negedge clk);
    redirect_valid = 1'b0;
    k = 0;
    for (int c = 0; c < 40 && k < 5; c++) begin
      if (inst_valid === 1'b1) begin
        exp_pc = 64'h100 + AW'(k * 4);
        checks++;
        if (pc !== exp_pc || inst !== mem_word(exp_pc)) begin
          failures++;
          $display("[TB] FAIL redir_seq[%0d]: pc=%h inst=%h required pc=%h inst=%h",
                   k, pc, inst, exp_pc, mem_word(exp_pc));
        end
        k++;
      end
      @(negedge clk);
    end
    checks++;
    if (k != 5) begin
      failures++;
      $display("[TB] FAIL redir_timeout: entries=%0d required 5", k);
    end
    mem_lat = 1;
  endtask

  task automatic test_simultaneous();
    int            waited;
    int            exp_drop;
    int            k;
    logic [AW-1:0] exp_pc;
    apply_reset();
    mem_lat = 2;
    stall   = 1'b1;
    waited  = 0;
    while (!(imem_rsp_valid && inst_valid && pend_addr.size() >= 2) && waited < 20) begin
      @(negedge clk);
      waited++;
    end
    exp_drop = pend_addr.size() - 1;
    checks++;
    if (exp_drop != 1) begin
      failures++;
      $display("[TB] FAIL simul_setup: inflight-1=%0d required 1", exp_drop);
    end
    redirect_valid = 1'b1;
    redirect_pc    = 64'h200;
    #1;
    checks++;
    if (imem_req_valid !== 1'b0 || inst_valid !== 1'b0) begin
      failures++;
      $display("[TB] FAIL simul_mask: req_valid=%b inst_valid=%b required 0/0",
               imem_req_valid, inst_valid);
    end
    @(negedge clk);
    redirect_valid = 1'b0;
    checks++;
    if (inst_valid !== 1'b0 || dut.drop_cnt_q !== 3'(exp_drop)) begin
      failures++;
      $display("[TB] FAIL simul_flush: inst_valid=%b drop_cnt=%0d required 0 drop_cnt=%0d",
               inst_valid, dut.drop_cnt_q, exp_drop);
    end
    stall = 1'b0;
    k = 0;
    for (int c = 0; c < 40 && k < 4; c++) begin
      if (inst_valid === 1'b1) begin
        exp_pc = 64'h200 + AW'(k * 4);
        checks++;
        if (pc !== exp_pc) begin
          failures++;
          $display("[TB] FAIL simul_seq[%0d]: pc=%h required %h", k, pc, exp_pc);
        end
        k++;
      end
      @(negedge clk);
    end
    checks++;
    if (k != 4) begin
      failures++;
      $display("[TB] FAIL simul_timeout: entries=%0d required 4", k);
    end
    mem_lat = 1;
  endtask

  task automatic test_fault();
    int            k;
    logic [AW-1:0] exp_pc;
    logic          exp_fault;
    apply_reset();
    err_armed = 1'b1;
    err_addr  = 64'h8;
`ifdef IF_FETCH_FAULT_EN
    k = 0;
    for (int c = 0; c < 30 && k < 4; c++) begin
      if (inst_valid === 1'b1) begin
        exp_pc    = AW'(k * 4);
        exp_fault = (k == 2);
        checks++;
        if (pc !== exp_pc || inst_fault !== exp_fault) begin
          failures++;
          $display("[TB] FAIL fault_seq[%0d]: pc=%h fault=%b required pc=%h fault=%b",
                   k, pc, inst_fault, exp_pc, exp_fault);
        end
        k++;
      end
      @(negedge clk);
    end
    repeat (4) @(negedge clk);
    checks++;
    if (k != 4 || imem_req_valid !== 1'b0 || inst_valid !== 1'b0) begin
      failures++;
      $display("[TB] FAIL fault_stop: entries=%0d req_valid=%b inst_valid=%b required 4/0/0",
               k, imem_req_valid, inst_valid);
    end
    redirect_valid = 1'b1;
    redirect_pc    = 64'h40;
    @(negedge clk);
    redirect_valid = 1'b0;
    k = 0;
    for (int c = 0; c < 30 && k < 3; c++) begin
      if (inst_valid === 1'b1) begin
        exp_pc = 64'h40 + AW'(k * 4);
        checks++;
        if (pc !== exp_pc || inst_fault !== 1'b0) begin
          failures++;
          $display("[TB] FAIL fault_resume[%0d]: pc=%h fault=%b required pc=%h fault=0",
                   k, pc, inst_fault, exp_pc);
        end
        k++;
      end
      @(negedge clk);
    end
    checks++;
    if (k != 3) begin
      failures++;
      $display("[TB] FAIL fault_resume_timeout: entries=%0d required 3", k);
    end
`else
    k = 0;
    for (int c = 0; c < 30 && k < 6; c++) begin
      if (inst_valid === 1'b1) begin
        exp_pc = AW'(k * 4);
        checks++;
        if (pc !== exp_pc || inst_fault !== 1'b0) begin
          failures++;
          $display("[TB] FAIL nofault_seq[%0d]: pc=%h fault=%b required pc=%h fault=0",
                   k, pc, inst_fault, exp_pc);
        end
        k++;
      end
      @(negedge clk);
    end
    checks++;
    if (k != 6) begin
      failures++;
      $display("[TB] FAIL nofault_timeout: entries=%0d required 6", k);
    end
`endif
    err_armed = 1'b0;
  endtask

  task automatic test_wrap();
    logic [AW-1:0] exp_w [4];
    int            k;
    exp_w[0] = WRAP_PC;
    exp_w[1] = 64'hFFFF_FFFF_FFFF_FFFC;
    exp_w[2] = 64'h0;
    exp_w[3] = 64'h4;
    apply_reset();
    @(negedge clk);
    checks++;
    if (w_req_valid !== 1'b1 || w_req_addr !== WRAP_PC) begin
      failures++;
      $display("[TB] FAIL wrap_first_req: req_valid=%b addr=%h required 1 addr=%h",
               w_req_valid, w_req_addr, WRAP_PC);
    end
    k = 0;
    for (int c = 0; c < 20 && k < 4; c++) begin
      if (w_inst_valid === 1'b1) begin
        checks++;
        if (w_pc !== exp_w[k] || w_inst !== mem_word(exp_w[k]) || w_inst_fault !== 1'b0) begin
          failures++;
          $display("[TB] FAIL wrap_seq[%0d]: pc=%h inst=%h fault=%b required pc=%h inst=%h fault=0",
                   k, w_pc, w_inst, w_inst_fault, exp_w[k], mem_word(exp_w[k]));
        end
        k++;
      end
      @(negedge clk);
    end
    checks++;
    if (k != 4) begin
      failures++;
      $display("[TB] FAIL wrap_timeout: entries=%0d required 4", k);
    end
  endtask

  // Scenario sequence.
  initial begin
    $display("[TB] stage_if_fetch directed tests");
    test_reset();
    test_run();
    test_backpressure();
    test_async_reset();
    test_redirect_inflight();
    test_simultaneous();
    test_fault();
    test_wrap();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Hard time limit so the run always ends.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
